// File: rtl/r16_tw_modmul_pkg.sv
// Shared constants and types for the radix-16 twiddle modular-multiply stage.
// Goldilocks modulus p = 2^64 - 2^32 + 1.
package r16_tw_modmul_pkg;

   localparam int unsigned D_WIDTH   = 64;
   localparam int unsigned LANES     = 16;
   localparam int unsigned FRAME_LEN = 4096;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

   localparam logic [D_WIDTH-1:0] GOLD_P = 64'hFFFF_FFFF_0000_0001;
   // 2^64 mod p; adding it folds a 2^64 carry back into range
   localparam logic [D_WIDTH-1:0] EPS    = 64'h0000_0000_FFFF_FFFF;

   typedef logic [D_WIDTH-1:0] word_t;

   // 128-bit product split into the three pieces the reduction works on
   typedef struct packed {
      word_t       x_lo;   // X[63:0]
      logic [31:0] hi_a;   // X[127:96], weight 2^96 == -1 mod p
      logic [31:0] hi_b;   // X[95:64],  weight 2^64 == 2^32-1 mod p
   } prod_split_t;

endpackage

// File: rtl/r16_tw_modmul_if.sv
// Beat bus between the delay stage, the twiddle multiplier and the next butterfly.
// master drives the input beat, slave (the multiplier) returns results.
interface r16_tw_modmul_if
   import r16_tw_modmul_pkg::*;
   ;

   logic                     in_valid;
   logic [LANES*D_WIDTH-1:0] in_data;
   logic [LANES*D_WIDTH-1:0] in_tw;
   logic                     frame_clr;
   logic                     out_valid;
   logic [LANES*D_WIDTH-1:0] out_data;
   logic                     out_last;
   logic [CNT_W-1:0]         beat_cnt;

   modport master (
      output in_valid, in_data, in_tw, frame_clr,
      input  out_valid, out_data, out_last, beat_cnt
   );

   modport slave (
      input  in_valid, in_data, in_tw, frame_clr,
      output out_valid, out_data, out_last, beat_cnt
   );

endinterface

// File: rtl/r16_tw_modmul_gold_modmul_pipe.sv
// Single-lane 3-stage Goldilocks multiply-reduce: r = (a*b) mod p, canonical.
// Stage 1 full product, stage 2 fold high words, stage 3 add and canonicalise.
module gold_modmul_pipe
   import r16_tw_modmul_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  word_t a,
   input  word_t b,
   output word_t r
);

   prod_split_t s1_q, s1_d;
   word_t       t0_q, t0_d;
   word_t       t1_q, t1_d;
   word_t       r_q,  r_d;

   logic [2*D_WIDTH-1:0] prod;
   logic [D_WIDTH:0]     diff;
   logic [D_WIDTH:0]     sum;
   word_t                fold;

   // stage 1: full 128-bit product and split
   always_comb begin
      prod = {{D_WIDTH{1'b0}}, a} * {{D_WIDTH{1'b0}}, b};
      s1_d = '{x_lo: prod[63:0], hi_a: prod[127:96], hi_b: prod[95:64]};
   end

   // stage 2: t0 = x_lo - hi_a (+p on borrow), t1 = hi_b*(2^32-1)
   always_comb begin
      diff = {1'b0, s1_q.x_lo} - {33'b0, s1_q.hi_a};
      t0_d = diff[D_WIDTH] ? (diff[D_WIDTH-1:0] - EPS) : diff[D_WIDTH-1:0];
      t1_d = {s1_q.hi_b, 32'b0} - {32'b0, s1_q.hi_b};
   end

   // stage 3: sum with carry fold, then a single conditional subtract of p
   always_comb begin
      sum  = {1'b0, t0_q} + {1'b0, t1_q};
      fold = sum[D_WIDTH] ? (sum[D_WIDTH-1:0] + EPS) : sum[D_WIDTH-1:0];
      r_d  = (fold >= GOLD_P) ? (fold - GOLD_P) : fold;
   end

   // pipeline registers, loaded every cycle regardless of valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         t0_q <= '0;
         t1_q <= '0;
         r_q  <= '0;
      end else begin
         s1_q <= s1_d;
         t0_q <= t0_d;
         t1_q <= t1_d;
         r_q  <= r_d;
      end
   end

   assign r = r_q;

endmodule

// File: rtl/r16_tw_modmul.sv
// 16-lane twiddle modular multiplier for the radix-16 65536-point NTT.
// Latency 3, no backpressure; tracks beat position within a 4096-beat frame.
// Optional build macro R16_TW_LANE0_BYPASS_EN: lane 0 is a plain 3-cycle delay
// of in_data[0] (its twiddle is always 1), saving one multiplier.
module r16_tw_modmul
   import r16_tw_modmul_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   r16_tw_modmul_if.slave bus
);

   logic [2:0]               vld_q, vld_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     last;
   logic [LANES*D_WIDTH-1:0] res;

`ifdef R16_TW_LANE0_BYPASS_EN
   localparam int FIRST_MUL = 1;

   logic [2:0][D_WIDTH-1:0] byp_q, byp_d;
   logic                    unused_tw0;

   // lane 0 delay line, same depth as the multiplier pipe
   always_comb begin
      byp_d = {byp_q[1:0], bus.in_data[D_WIDTH-1:0]};
   end

   // lane 0 delay registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byp_q <= '0;
      else        byp_q <= byp_d;
   end

   assign res[D_WIDTH-1:0] = byp_q[2];
   assign unused_tw0       = ^bus.in_tw[D_WIDTH-1:0];
`else
   localparam int FIRST_MUL = 0;
`endif

   for (genvar k = FIRST_MUL; k < int'(LANES); k++) begin : g_lane
      gold_modmul_pipe u_mul (
         .clk   (clk),
         .rst_n (rst_n),
         .a     (bus.in_data[k*D_WIDTH +: D_WIDTH]),
         .b     (bus.in_tw[k*D_WIDTH +: D_WIDTH]),
         .r     (res[k*D_WIDTH +: D_WIDTH])
      );
   end

   // valid shift register and frame beat counter next-state
   always_comb begin
      vld_d = {vld_q[1:0], bus.in_valid};
      last  = vld_q[2] && (cnt_q == CNT_W'(FRAME_LEN - 1));
      cnt_d = cnt_q;
      if (bus.frame_clr)  cnt_d = '0;
      else if (vld_q[2])  cnt_d = last ? '0 : cnt_q + CNT_W'(1);
   end

   // valid/counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.out_valid = vld_q[2];
   assign bus.out_last  = last;
   assign bus.beat_cnt  = cnt_q;
   assign bus.out_data  = res;

endmodule

// File: doc/r16_tw_modmul.md
Name: r16_tw_modmul

Overview:
- Downstream neighbour of the 16-lane 21-cycle data/twiddle delay stage in the radix-16 65536-point NTT datapath.
- Consumes 16 delayed data words and 16 twiddle factors per beat.
- Performs a fully pipelined Goldilocks modular multiply per lane (p = 2^64 - 2^32 + 1).
- Tracks frame position and emits results to the next radix-16 butterfly stage.

Parameters:
- D_WIDTH, 64, word width; fixed by the modulus and not to be overridden.
- LANES, 16, lanes per beat; fixed.
- FRAME_LEN, 4096, valid beats per NTT frame (65536/16).
- CNT_W, 12, width of frame beat counter, equal to clog2(FRAME_LEN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat qualifier for in_data/in_tw
- in_data  in  LANES*D_WIDTH  lane k at bits [k*64 +: 64]
- in_tw  in  LANES*D_WIDTH  twiddle for lane k, same packing
- frame_clr  in  1  synchronous clear of beat counter
- out_valid  out  1  result qualifier
- out_data  out  LANES*D_WIDTH  (in_data[k]*in_tw[k]) mod p, canonical
- out_last  out  1  high with the FRAME_LEN-th valid beat of a frame
- beat_cnt  out  CNT_W  index of the current out_valid beat within the frame

Behaviour:
- Reset is async on rst_n low. All pipeline registers, out_valid, out_data, out_last and beat_cnt clear to 0.
- No backpressure. A new beat is accepted every cycle in_valid=1.
- Latency is exactly 3 cycles: in_valid at cycle t gives out_valid at t+3. Valid bubbles propagate unchanged.
- Data registers load every cycle; they are not gated by valid. out_data is don't-care when out_valid=0, but is 0 after reset.
- Stage 1: X = a*b, 128-bit full product. Split X into x_lo = X[63:0], hi_a = X[127:96] and hi_b = X[95:64].
- Stage 2:
  - t0 = x_lo - hi_a (65-bit). If borrow, t0 = t0 - 0xFFFFFFFF, which is equivalent to adding p; keep 64 bits.
  - t1 = (hi_b<<32) - hi_b.
- Stage 3:
  - r = t0 + t1. If carry out, r = r + 0xFFFFFFFF.
  - If r >= p, r = r - p.
  - Register r to out_data.
- Outputs are canonical in [0, p-1] for any 64-bit inputs, including non-canonical ones.
- Beat counter:
  - beat_cnt is the count of out_valid beats modulo FRAME_LEN.
  - out_last = out_valid && (beat_cnt == FRAME_LEN-1) and is combinational off the registered count.
  - After a last beat, the count wraps to 0.
- frame_clr:
  - Sets beat_cnt to 0 on the next edge.
  - If it coincides with an out_valid beat, that beat is reported with its pre-clear beat_cnt/out_last, and the count becomes 0, not +1.
  - frame_clr never flushes the data pipeline.
- Reset mid-frame discards in-flight beats; the counter restarts at 0.

Optional Feature:
- R16_TW_LANE0_BYPASS_EN:
  - When defined, lane 0 skips the multiplier. in_data[0] is passed through a 3-register delay and in_tw[0] is ignored (lane-0 twiddle is always 1 in this schedule). This saves one 64x64 multiplier.
  - When undefined, lane 0 multiplies like every other lane.
  - Both builds must give identical results when in_tw[0] = 1 and in_data[0] < p.

Decomposition:
- Shared package/defines file:
  - D_width, which the datapath already uses.
  - GOLD_P = 64'hFFFF_FFFF_0000_0001.
  - EPS = 64'h0000_0000_FFFF_FFFF.
  - FRAME_LEN/CNT_W.
- One sub-module, gold_modmul_pipe: single-lane 3-stage multiply-reduce with ports clk, rst_n, a, b, r.
  - The top instantiates it LANES times (LANES-1 when bypass is enabled).
  - The top holds the valid shift register and the beat counter.

Test Plan:
- Lane arithmetic:
  - (p-1)*(p-1) -> 1.
  - 2^32*2^32 -> 0x00000000FFFFFFFF.
  - 2^48*2^48 -> 0xFFFFFFFF00000000.
  - 0xFFFFFFFFFFFFFFFF*1 -> 0x00000000FFFFFFFE.
  - x*0 -> 0.
  - Apply all on different lanes of one beat; out_valid exactly 3 cycles later.
- Random canonical and non-canonical operands, 10k beats with in_valid ~70% random:
  - Every output matches a reference model mod p.
  - Outputs are canonical.
  - Valid gaps are preserved with latency 3.
- Continuous in_valid for 8192 beats:
  - out_last pulses on beats 4095 and 8191 only.
  - beat_cnt is 0 on beats 0 and 4096.
- frame_clr asserted on the same cycle as the out_valid beat with beat_cnt=100:
  - That beat shows 100.
  - The next valid beat shows 0.
  - Data is unaffected.
- rst_n low for 1 cycle while 2 beats are in flight:
  - Those beats never appear.
  - out_valid=0 and beat_cnt=0 immediately on assertion, asynchronously.
  - The first post-reset beat reports beat_cnt=0.
- Build with R16_TW_LANE0_BYPASS_EN:
  - in_data[0]=0x123, in_tw[0]=0xDEAD -> out lane0=0x123 at latency 3.
  - Other lanes are unchanged.
